// File: rtl/gshare_predict_ctrl.sv
// Gshare lookup/update controller for a shared 16-entry 2-bit-counter BHT.
// Optional saturating statistics counters are enabled with PRED_STATS_EN.
module gshare_predict_ctrl #(
    parameter int INDEX_W = 4,
    parameter int HIST_W  = 4,
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [INDEX_W-1:0] req_pc,
    output logic               resp_valid,
    output logic               resp_taken,
    output logic [TAG_W-1:0]   resp_tag,
    input  logic               res_valid,
    input  logic               res_taken,
    output logic               res_err,
    output logic               flush,
    output logic [INDEX_W-1:0] bht_index,
    output logic               bht_update_en,
    output logic               bht_actual,
    input  logic               bht_prediction,
    output logic [15:0]        stat_lookups,
    output logic [15:0]        stat_mispred
);

    localparam int CNT_W = TAG_W + 1;

    typedef struct packed {
        logic [INDEX_W-1:0] idx;
        logic               pred;
        logic [HIST_W-1:0]  snap;
    } ent_t;

    ent_t              q_q [DEPTH];
    ent_t              q_d [DEPTH];
    logic [HIST_W-1:0] ghr_q, ghr_d;
    logic [TAG_W-1:0]  head_q, head_d;
    logic [TAG_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_taken_q, resp_taken_d;
    logic [TAG_W-1:0]  resp_tag_q, resp_tag_d;
    logic              res_err_q, res_err_d;
    logic              flush_q, flush_d;

    logic               res_do;
    logic               acc;
    logic               mispred;
    logic [INDEX_W-1:0] look_idx;

    function automatic logic [HIST_W-1:0] shift_in(
        input logic [HIST_W-1:0] h,
        input logic              b
    );
        logic [HIST_W:0] t;
        t = {h, b};
        return t[HIST_W-1:0];
    endfunction

    // Reset gates the write strobe so no counter moves in a reset cycle.
    assign res_do    = reset && res_valid && (count_q != '0);
    assign req_ready = (count_q < CNT_W'(DEPTH)) && !res_valid;
    assign acc       = req_valid && req_ready;
    assign look_idx  = req_pc ^ INDEX_W'(ghr_q);
    assign mispred   = res_do && (q_q[head_q].pred != res_taken);

    assign bht_index     = res_do ? q_q[head_q].idx : look_idx;
    assign bht_update_en = res_do;
    assign bht_actual    = res_do && res_taken;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) q_d[i] = q_q[i];
        ghr_d        = ghr_q;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        resp_valid_d = 1'b0;
        resp_taken_d = resp_taken_q;
        resp_tag_d   = resp_tag_q;
        res_err_d    = res_valid && (count_q == '0);
        flush_d      = 1'b0;
        if (res_do) begin
            head_d  = head_q + 1'b1;
            count_d = count_q - 1'b1;
            if (mispred) begin
                ghr_d   = shift_in(q_q[head_q].snap, res_taken);
                head_d  = tail_q;
                count_d = '0;
                flush_d = 1'b1;
            end
        end else if (acc) begin
            q_d[tail_q]  = '{idx: look_idx, pred: bht_prediction, snap: ghr_q};
            tail_d       = tail_q + 1'b1;
            count_d      = count_q + 1'b1;
            ghr_d        = shift_in(ghr_q, bht_prediction);
            resp_valid_d = 1'b1;
            resp_taken_d = bht_prediction;
            resp_tag_d   = tail_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) q_q[i] <= '0;
            ghr_q        <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_taken_q <= 1'b0;
            resp_tag_q   <= '0;
            res_err_q    <= 1'b0;
            flush_q      <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) q_q[i] <= q_d[i];
            ghr_q        <= ghr_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            resp_valid_q <= resp_valid_d;
            resp_taken_q <= resp_taken_d;
            resp_tag_q   <= resp_tag_d;
            res_err_q    <= res_err_d;
            flush_q      <= flush_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_taken = resp_taken_q;
    assign resp_tag   = resp_tag_q;
    assign res_err    = res_err_q;
    assign flush      = flush_q;

`ifdef PRED_STATS_EN
    logic [15:0] lk_q, lk_d;
    logic [15:0] mp_q, mp_d;

    always_comb begin
        lk_d = lk_q;
        mp_d = mp_q;
        if (acc && lk_q != 16'hFFFF) lk_d = lk_q + 16'd1;
        if (mispred && mp_q != 16'hFFFF) mp_d = mp_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            lk_q <= '0;
            mp_q <= '0;
        end else begin
            lk_q <= lk_d;
            mp_q <= mp_d;
        end
    end

    assign stat_lookups = lk_q;
    assign stat_mispred = mp_q;
`else
    assign stat_lookups = 16'h0000;
    assign stat_mispred = 16'h0000;
`endif

endmodule

// File: tb/tb_gshare_predict_ctrl.sv
// Bench for gshare_predict_ctrl: directed vector table plus random traffic
// against a queue-based reference model, with a 2-bit-counter BHT alongside.
module tb_gshare_predict_ctrl;

    localparam int DEPTH = 4;
    localparam int HM    = 15;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_pc;
    logic        resp_valid;
    logic        resp_taken;
    logic [1:0]  resp_tag;
    logic        res_valid;
    logic        res_taken;
    logic        res_err;
    logic        flush;
    logic [3:0]  bht_index;
    logic        bht_update_en;
    logic        bht_actual;
    logic        bht_prediction;
    logic [15:0] stat_lookups;
    logic [15:0] stat_mispred;

    gshare_predict_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_pc         (req_pc),
        .resp_valid     (resp_valid),
        .resp_taken     (resp_taken),
        .resp_tag       (resp_tag),
        .res_valid      (res_valid),
        .res_taken      (res_taken),
        .res_err        (res_err),
        .flush          (flush),
        .bht_index      (bht_index),
        .bht_update_en  (bht_update_en),
        .bht_actual     (bht_actual),
        .bht_prediction (bht_prediction),
        .stat_lookups   (stat_lookups),
        .stat_mispred   (stat_mispred)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared BHT: combinational read, saturating counter write on strobe.
    logic [1:0] bht [16] = '{default: 2'b00};
    assign bht_prediction = bht[bht_index][1];
    always @(posedge clk) begin
        if (bht_update_en) begin
            if (bht_actual && bht[bht_index] != 2'b11)
                bht[bht_index] <= bht[bht_index] + 2'b01;
            else if (!bht_actual && bht[bht_index] != 2'b00)
                bht[bht_index] <= bht[bht_index] - 2'b01;
        end
    end

    typedef struct {
        bit rst; bit rv; int pc; bit sv; bit st;
        bit rdy; int idx; bit upd; bit act;
        bit orv; bit ort; int otag; bit ofl; bit oerr;
    } vec_t;

    typedef struct {
        int idx;
        bit pred;
        int snap;
    } ent_t;

    ent_t m_q[$];
    int   m_ghr, m_nacc, m_lk, m_mp;
    int   n_tests, n_fail;

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    function automatic vec_t mk(bit rst, bit rv, int pc, bit sv, bit st,
                                bit rdy, int idx, bit upd, bit act,
                                bit orv, bit ort, int otag, bit ofl,
                                bit oerr);
        vec_t v;
        v = '{rst, rv, pc, sv, st, rdy, idx, upd, act,
              orv, ort, otag, ofl, oerr};
        return v;
    endfunction

    task automatic step(input bit rst, input bit rv, input int pc,
                        input bit sv, input bit st, input bit use_v,
                        input vec_t v);
        bit   m_resdo, m_ready, m_pred, e_rv, e_rt, e_fl, e_err;
        int   m_index, e_tag;
        ent_t e;
        @(negedge clk);
        reset     = !rst;
        req_valid = rv;
        req_pc    = 4'(pc);
        res_valid = sv;
        res_taken = st;
        #1;
        m_resdo = sv && m_q.size() > 0;
        m_ready = m_q.size() < DEPTH && !sv;
        m_index = m_resdo ? m_q[0].idx : ((pc ^ m_ghr) & HM);
        if (rst) begin
            chk("upd_in_reset", 32'(bht_update_en), 32'(0));
        end else if (use_v) begin
            chk("t_ready", 32'(req_ready), 32'(v.rdy));
            chk("t_index", 32'(bht_index), v.idx);
            chk("t_upd", 32'(bht_update_en), 32'(v.upd));
            chk("t_actual", 32'(bht_actual), 32'(v.act));
        end else begin
            chk("ready", 32'(req_ready), 32'(m_ready));
            chk("index", 32'(bht_index), m_index);
            chk("upd", 32'(bht_update_en), 32'(m_resdo));
            chk("actual", 32'(bht_actual), 32'(m_resdo && st));
        end
        m_pred = bht[4'(m_index)][1];
        e_rv = 0; e_rt = 0; e_tag = 0; e_fl = 0; e_err = 0;
        if (rst) begin
            m_q.delete();
            m_ghr = 0; m_nacc = 0; m_lk = 0; m_mp = 0;
        end else begin
            e_err = sv && m_q.size() == 0;
            if (m_resdo) begin
                e = m_q.pop_front();
                if (e.pred != st) begin
                    m_ghr = ((e.snap << 1) | int'(st)) & HM;
                    m_q.delete();
                    e_fl = 1;
                    if (m_mp < 65535) m_mp++;
                end
            end else if (rv && m_ready) begin
                m_q.push_back('{m_index, m_pred, m_ghr});
                m_ghr = ((m_ghr << 1) | int'(m_pred)) & HM;
                e_rv  = 1;
                e_rt  = m_pred;
                e_tag = m_nacc % DEPTH;
                m_nacc++;
                if (m_lk < 65535) m_lk++;
            end
        end
        @(posedge clk);
        #1;
        if (use_v) begin
            chk("t_resp_valid", 32'(resp_valid), 32'(v.orv));
            if (v.orv) begin
                chk("t_resp_taken", 32'(resp_taken), 32'(v.ort));
                chk("t_resp_tag", 32'(resp_tag), v.otag);
            end
            chk("t_flush", 32'(flush), 32'(v.ofl));
            chk("t_res_err", 32'(res_err), 32'(v.oerr));
        end else begin
            chk("resp_valid", 32'(resp_valid), 32'(e_rv));
            if (e_rv) begin
                chk("resp_taken", 32'(resp_taken), 32'(e_rt));
                chk("resp_tag", 32'(resp_tag), e_tag);
            end
            chk("flush", 32'(flush), 32'(e_fl));
            chk("res_err", 32'(res_err), 32'(e_err));
        end
`ifdef PRED_STATS_EN
        chk("stat_lookups", 32'(stat_lookups), m_lk);
        chk("stat_mispred", 32'(stat_mispred), m_mp);
`else
        chk("stat_lookups_off", 32'(stat_lookups), 32'(0));
        chk("stat_mispred_off", 32'(stat_mispred), 32'(0));
`endif
    endtask

    vec_t tbl[$];
    vec_t none;

    initial begin
        n_tests = 0; n_fail = 0;
        m_ghr = 0; m_nacc = 0; m_lk = 0; m_mp = 0;
        reset = 1'b0; req_valid = 1'b1; req_pc = '0;
        res_valid = 1'b0; res_taken = 1'b0;
        none = mk(0,0,0,0,0, 0,0,0,0, 0,0,0,0,0);

        // rst rv pc sv st | rdy idx upd act | orv ort tag fl err
        tbl.push_back(mk(1,1,0,0,0, 0,0,0,0, 0,0,0,0,0));
        tbl.push_back(mk(1,1,0,0,0, 0,0,0,0, 0,0,0,0,0));
        tbl.push_back(mk(0,1,5,0,0, 1,5,0,0, 1,0,0,0,0));
        tbl.push_back(mk(0,0,0,1,1, 0,5,1,1, 0,0,0,1,0));
        tbl.push_back(mk(0,0,0,0,0, 1,1,0,0, 0,0,0,0,0));
        tbl.push_back(mk(1,1,3,0,0, 0,0,0,0, 0,0,0,0,0));
        tbl.push_back(mk(1,1,3,0,0, 0,0,0,0, 0,0,0,0,0));
        tbl.push_back(mk(0,1,2,0,0, 1,2,0,0, 1,0,0,0,0));
        tbl.push_back(mk(0,1,5,0,0, 1,5,0,0, 1,0,1,0,0));
        tbl.push_back(mk(0,1,6,0,0, 1,6,0,0, 1,0,2,0,0));
        tbl.push_back(mk(0,1,7,0,0, 1,7,0,0, 1,0,3,0,0));
        tbl.push_back(mk(0,1,9,0,0, 0,9,0,0, 0,0,0,0,0));
        tbl.push_back(mk(0,1,9,1,0, 0,2,1,0, 0,0,0,0,0));
        tbl.push_back(mk(0,1,9,0,0, 1,9,0,0, 1,0,0,0,0));
        tbl.push_back(mk(0,0,0,1,0, 0,5,1,0, 0,0,0,0,0));
        tbl.push_back(mk(0,0,0,1,0, 0,6,1,0, 0,0,0,0,0));
        tbl.push_back(mk(0,0,0,1,0, 0,7,1,0, 0,0,0,0,0));
        tbl.push_back(mk(0,0,0,1,0, 0,9,1,0, 0,0,0,0,0));
        tbl.push_back(mk(0,0,0,1,0, 0,0,0,0, 0,0,0,0,1));
        tbl.push_back(mk(0,0,0,0,0, 1,0,0,0, 0,0,0,0,0));

        foreach (tbl[i])
            step(tbl[i].rst, tbl[i].rv, tbl[i].pc, tbl[i].sv, tbl[i].st,
                 1'b1, tbl[i]);

        // Mid-flight reset with a pending resolution: no BHT write.
        step(0, 1, 4'hA, 0, 0, 1'b0, none);
        step(0, 1, 4'h3, 0, 0, 1'b0, none);
        step(1, 0, 0, 1, 1, 1'b0, none);
        step(0, 0, 0, 1, 0, 1'b0, none);

        for (int n = 0; n < 800; n++) begin
            step($urandom_range(0, 149) == 0,
                 $urandom_range(0, 9) < 7,
                 int'($urandom_range(0, 15)),
                 $urandom_range(0, 9) < 3,
                 $urandom_range(0, 9) < 6,
                 1'b0, none);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gshare_predict_ctrl.md
Name: gshare_predict_ctrl

Overview:
Initiator-side controller for the shared 16-entry 2-bit-counter BHT. Takes fetch lookups (PC bits), forms the gshare index (PC XOR speculative global history) and returns the BHT prediction to fetch. Tracks in-flight predictions in an in-order queue and issues counter updates to the BHT on branch resolution. Repairs the global history register (GHR) and flushes fetch on a mispredict.

Parameters:
INDEX_W, 4, BHT index width; 16 entries by default.
HIST_W, 4, GHR width; 1..INDEX_W, zero-extended to INDEX_W for the XOR.
DEPTH, 4, in-flight queue entries; power of 2.
TAG_W, 2, log2(DEPTH); the tag is the queue slot number.

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
req_valid  in  1  fetch lookup request
req_ready  out  1  lookup accepted when req_valid && req_ready
req_pc  in  INDEX_W  low PC bits of the branch
resp_valid  out  1  prediction result valid, one-cycle pulse
resp_taken  out  1  predicted direction
resp_tag  out  TAG_W  queue slot of this prediction
res_valid  in  1  oldest in-flight branch resolved
res_taken  in  1  actual outcome
res_err  out  1  pulse: res_valid arrived with the queue empty
flush  out  1  pulse: mispredict detected; fetch discards all outstanding predictions
bht_index  out  INDEX_W  to the BHT index input
bht_update_en  out  1  to the BHT predict_enable (counter write strobe)
bht_actual  out  1  to the BHT actual_outcome
bht_prediction  in  1  from the BHT, combinational read of bht_index
stat_lookups  out  16  lookup count (optional feature)
stat_mispred  out  16  mispredict count (optional feature)

Behaviour:
- Reset (reset==0 at a clk edge) clears:
  - GHR to 0 and the queue to empty (head, tail, count = 0).
  - resp_valid, resp_taken, resp_tag, res_err and flush to 0.
  - Stat counters to 0.
- Reset overrides all other activity in that cycle. Mid-operation reset discards every in-flight entry; no BHT write occurs in the reset cycle.
- Index mux (combinational):
  - res_valid && count>0: bht_index = queue[head].index, bht_update_en=1, bht_actual=res_taken.
  - Otherwise: bht_index = req_pc ^ zext(GHR), bht_update_en=0, bht_actual=0.
- req_ready = (count<DEPTH) && !res_valid. Resolution has priority over lookup, since the BHT has one index port.
- Lookup accept, cycle N:
  - Sample bht_prediction.
  - Write {index, pred, GHR snapshot} to queue[tail]; tail++ (wraps mod DEPTH); count++.
  - GHR <= {GHR[HIST_W-2:0], pred}.
  - Cycle N+1: resp_valid=1, resp_taken=pred, resp_tag=old tail. resp_valid is 0 in every other cycle.
- Resolution, cycle N (res_valid && count>0):
  - The BHT counter at the stored index updates at the clk edge.
  - head++ (wraps); count--.
  - Correct prediction (pred==res_taken): GHR unchanged.
  - Mispredict:
    - GHR <= {snapshot[HIST_W-2:0], res_taken}.
    - The queue is emptied: head=tail, count=0.
    - flush=1 in cycle N+1.
  - A resp_valid pulse in cycle N+1 that belongs to a flushed entry is still driven. Fetch ignores any resp_valid that coincides with flush.
- res_valid && count==0: no BHT write, no state change; res_err=1 in cycle N+1.
- Full (count==DEPTH): req_ready=0; a resolution in the same cycle frees one slot from cycle N+1.
- Only one queue operation per cycle, because req_ready is low whenever res_valid is high.

Optional Feature:
PRED_STATS_EN
- Defined:
  - stat_lookups increments on each accepted lookup.
  - stat_mispred increments on each mispredict.
  - Both saturate at 16'hFFFF and clear on reset.
- Undefined: both outputs tied to 16'h0000; no counter flops.

Test Plan:
- Reset: hold reset=0 for 2 cycles with req_valid=1 -> resp_valid=0, flush=0, res_err=0; first post-reset lookup uses GHR=0.
- Lookup with GHR=0, req_pc=4'h5, BHT counter 00 -> bht_index=5; next cycle resp_valid=1, resp_taken=0, resp_tag=0; GHR=4'b0000.
- Resolve that entry with res_taken=1 -> bht_update_en=1, bht_index=5, bht_actual=1; next cycle flush=1; GHR=4'b0001; queue empty; stat_mispred=1 with PRED_STATS_EN.
- Issue 4 lookups with no resolution -> req_ready=0 after the 4th; tags 0,1,2,3; a 5th req_valid is not accepted until a correct resolution, after which the next lookup gets tag 0 (wrap).
- req_valid=1 and res_valid=1 in the same cycle (correct prediction) -> req_ready=0, BHT write at the head index, no resp_valid next cycle; the lookup is accepted the following cycle.
- res_valid=1 with queue empty -> res_err=1 next cycle, bht_update_en=0, GHR unchanged.
